slot_allocator: RTL and testbench

- Parametrised multi-way free-slot allocator; successor to the single one-hot encoder.
- Tracks a registered free bitmap of SLOTS entries.
- Each cycle it grants up to ALLOC_WAYS lowest-numbered free slots, as encoded indices, and accepts up to FREE_WAYS returned indices.
- Serves RS/ROB/physical-register free lists in the R10K pipeline, with flush recovery and double-free detection.

---
 rtl/slot_allocator_pkg.sv | 12 +
 rtl/slot_allocator_multi_psel_enc.sv | 35 +++
 rtl/slot_allocator.sv | 113 +++++++++++
 tb/tb_slot_allocator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/slot_allocator_pkg.sv
// Shared defaults for the free-list allocators (RS, ROB, physical registers).
package slot_allocator_pkg;

  localparam int DEF_SLOTS      = 16;
  localparam int DEF_ALLOC_WAYS = 2;
  localparam int DEF_FREE_WAYS  = 2;

  localparam int RS_SLOTS   = 16;
  localparam int ROB_SLOTS  = 32;
  localparam int PREG_SLOTS = 64;

endpackage

// File: rtl/slot_allocator_multi_psel_enc.sv
// Returns the WAYS lowest set bits of req as encoded indices with per-way valid bits.
module multi_psel_enc #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 2,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]      req,
  output logic [WAYS-1:0]       valid,
  output logic [WAYS*IDX_W-1:0] idx
);

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] lowest;
  logic [IDX_W-1:0] enc;

  // Each pass isolates the lowest remaining set bit, one-hot encodes it, then masks it off.
  always_comb begin
    mask   = req;
    lowest = '0;
    enc    = '0;
    valid  = '0;
    idx    = '0;
    for (int w = 0; w < WAYS; w++) begin
      lowest = mask & (~mask + 1'b1);
      enc    = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (lowest[i]) enc = enc | IDX_W'(i);
      end
      valid[w]                 = |mask;
      idx[w*IDX_W +: IDX_W]    = enc;
      mask                     = mask & ~lowest;
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// Multi-way free-slot allocator: grants the lowest free slots, accepts returns,
// recovers on flush and flags double frees.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int SLOTS      = DEF_SLOTS,
  parameter int ALLOC_WAYS = DEF_ALLOC_WAYS,
  parameter int FREE_WAYS  = DEF_FREE_WAYS,
  localparam int IDX_W     = $clog2(SLOTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [ALLOC_WAYS-1:0]       alloc_req,
  output logic [ALLOC_WAYS-1:0]       alloc_gnt,
  output logic [ALLOC_WAYS*IDX_W-1:0] alloc_idx,
  input  logic [FREE_WAYS-1:0]        free_valid,
  input  logic [FREE_WAYS*IDX_W-1:0]  free_idx,
  output logic [IDX_W:0]              free_count,
  output logic                        none_free,
  output logic                        err_double_free
);

  logic [SLOTS-1:0]            free_map;
  logic [SLOTS-1:0]            nxt_map;
  logic [IDX_W:0]              nxt_count;
  logic                        dbl;
  logic                        dup;
  logic                        active;
  logic [ALLOC_WAYS-1:0]       sel_vld;
  logic [ALLOC_WAYS*IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0]            fi;
  int                          rank;

  assign active = reset & ~flush;

  multi_psel_enc #(
    .WIDTH (SLOTS),
    .WAYS  (ALLOC_WAYS)
  ) u_sel (
    .req   (free_map),
    .valid (sel_vld),
    .idx   (sel_idx)
  );

  // Handshake: alloc_req is a per-way request; alloc_gnt answers in the same cycle
  // and a slot is consumed only on the edge where gnt is high. free_valid is an
  // unconditional strobe, always accepted.
  always_comb begin
    alloc_gnt = '0;
    alloc_idx = '0;
    rank      = 0;
    for (int w = 0; w < ALLOC_WAYS; w++) begin
      if (active && alloc_req[w]) begin
        for (int k = 0; k < ALLOC_WAYS; k++) begin
          if (k == rank && sel_vld[k]) begin
            alloc_gnt[w]                = 1'b1;
            alloc_idx[w*IDX_W +: IDX_W] = sel_idx[k*IDX_W +: IDX_W];
          end
        end
        rank = rank + 1;
      end
    end
  end

  // A free of an already-free slot, or a repeat within the cycle, leaves the bit untouched.
  always_comb begin
    nxt_map = free_map;
    dbl     = 1'b0;
    dup     = 1'b0;
    fi      = '0;
    for (int w = 0; w < ALLOC_WAYS; w++) begin
      if (alloc_gnt[w]) nxt_map[alloc_idx[w*IDX_W +: IDX_W]] = 1'b0;
    end
    for (int f = 0; f < FREE_WAYS; f++) begin
      if (free_valid[f]) begin
        fi  = free_idx[f*IDX_W +: IDX_W];
        dup = 1'b0;
        for (int g = 0; g < f; g++) begin
          if (free_valid[g] && free_idx[g*IDX_W +: IDX_W] == fi) dup = 1'b1;
        end
        if (free_map[fi] || dup) dbl = 1'b1;
        else                     nxt_map[fi] = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_count = '0;
    for (int i = 0; i < SLOTS; i++) begin
      nxt_count = nxt_count + (IDX_W+1)'(nxt_map[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      free_map        <= '1;
      free_count      <= (IDX_W+1)'(SLOTS);
      none_free       <= 1'b0;
      err_double_free <= 1'b0;
    end else if (flush) begin
      free_map        <= '1;
      free_count      <= (IDX_W+1)'(SLOTS);
      none_free       <= 1'b0;
    end else begin
      free_map        <= nxt_map;
      free_count      <= nxt_count;
      none_free       <= (nxt_count == '0);
      err_double_free <= err_double_free | dbl;
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Directed-vector bench for slot_allocator with SLOTS=8, two alloc and two free ways.
module tb_slot_allocator;

  localparam int SLOTS = 8;
  localparam int AW    = 2;
  localparam int FW    = 2;
  localparam int IW    = 3;

  logic          clock;
  logic          reset;
  logic          flush;
  logic [AW-1:0] alloc_req;
  logic [AW-1:0] alloc_gnt;
  logic [AW*IW-1:0] alloc_idx;
  logic [FW-1:0] free_valid;
  logic [FW*IW-1:0] free_idx;
  logic [IW:0]   free_count;
  logic          none_free;
  logic          err_double_free;

  int n_vec;
  int n_err;
  logic [IW-1:0] exp_q[$];

  slot_allocator #(
    .SLOTS      (SLOTS),
    .ALLOC_WAYS (AW),
    .FREE_WAYS  (FW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .alloc_req       (alloc_req),
    .alloc_gnt       (alloc_gnt),
    .alloc_idx       (alloc_idx),
    .free_valid      (free_valid),
    .free_idx        (free_idx),
    .free_count      (free_count),
    .none_free       (none_free),
    .err_double_free (err_double_free)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // free_count must track the popcount of the live bitmap
  task automatic check_inv();
    logic [IW:0] pc;
    pc = '0;
    for (int i = 0; i < SLOTS; i++) pc = pc + (IW+1)'(dut.free_map[i]);
    check("count_invariant", 32'(free_count), 32'(pc));
  endtask

  // drivers
  task automatic apply(input logic [1:0] req, input logic [1:0] fv,
                       input logic [2:0] f0, input logic [2:0] f1, input logic fl);
    alloc_req  = req;
    free_valid = fv;
    free_idx   = {f1, f0};
    flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_inv();
  endtask

  task automatic idle();
    apply(2'b00, 2'b00, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    logic [IW-1:0] e0, e1;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;
    // grants forced off while reset is low
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    check("gnt_in_reset", 32'(alloc_gnt), 32'h0);
    tick();
    check("reset_count", 32'(free_count), 32'd8);
    check("reset_none_free", 32'(none_free), 32'd0);
    check("reset_err", 32'(err_double_free), 32'd0);
    reset = 1'b1;

    // 1/2: drain all eight slots two at a time, lowest first
    for (int s = 0; s < SLOTS; s++) exp_q.push_back(IW'(s));
    for (int k = 0; k < 4; k++) begin
      apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      check("drain_gnt", 32'(alloc_gnt), 32'h3);
      check("drain_idx", 32'(alloc_idx), 32'({e1, e0}));
      tick();
      check("drain_count", 32'(free_count), 32'(8 - 2*(k+1)));
    end
    check("full_none_free", 32'(none_free), 32'd1);
    apply(2'b11, 2'b01, 3'd5, 3'd0, 1'b0);
    check("full_gnt", 32'(alloc_gnt), 32'h0);
    check("full_idx", 32'(alloc_idx), 32'h0);
    tick();
    check("freed_count", 32'(free_count), 32'd1);
    check("freed_none_free", 32'(none_free), 32'd0);
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    check("one_free_gnt", 32'(alloc_gnt), 32'h1);
    check("one_free_idx", 32'(alloc_idx), 32'd5);
    tick();
    check("refill_count", 32'(free_count), 32'd0);
    check("refill_none_free", 32'(none_free), 32'd1);

    // 3: only way 1 requests
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
    apply(2'b10, 2'b00, 3'd0, 3'd0, 1'b0);
    check("way1_gnt", 32'(alloc_gnt), 32'h2);
    check("way1_idx", 32'(alloc_idx), 32'h0);
    tick();
    check("way1_count", 32'(free_count), 32'd7);

    // 4: double free of an already-free slot
    apply(2'b00, 2'b01, 3'd3, 3'd0, 1'b0);
    tick();
    check("dbl_err", 32'(err_double_free), 32'd1);
    check("dbl_count", 32'(free_count), 32'd7);
    idle();
    tick();
    check("dbl_sticky", 32'(err_double_free), 32'd1);
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    check("alloc12_idx", 32'(alloc_idx), 32'({3'd2, 3'd1}));
    tick();
    check("alloc12_count", 32'(free_count), 32'd5);
    apply(2'b00, 2'b11, 3'd2, 3'd2, 1'b0);
    tick();
    check("dup_free_count", 32'(free_count), 32'd6);
    check("dup_free_err", 32'(err_double_free), 32'd1);
    apply(2'b01, 2'b00, 3'd0, 3'd0, 1'b0);
    check("slot2_free_gnt", 32'(alloc_gnt), 32'h1);
    check("slot2_free_idx", 32'(alloc_idx), 32'd2);

    // 5: flush with six slots allocated (0,1 held; take 2..5)
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    tick();
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    tick();
    check("six_alloc_count", 32'(free_count), 32'd2);
    apply(2'b11, 2'b11, 3'd0, 3'd6, 1'b1);
    check("flush_gnt", 32'(alloc_gnt), 32'h0);
    tick();
    check("flush_count", 32'(free_count), 32'd8);
    check("flush_none_free", 32'(none_free), 32'd0);
    check("flush_err_kept", 32'(err_double_free), 32'd1);

    // 6: reset mid-operation overrides alloc and free
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    tick();
    check("pre_reset_count", 32'(free_count), 32'd6);
    reset = 1'b0;
    apply(2'b11, 2'b11, 3'd0, 3'd1, 1'b0);
    check("midreset_gnt", 32'(alloc_gnt), 32'h0);
    tick();
    reset = 1'b1;
    idle();
    check("post_reset_count", 32'(free_count), 32'd8);
    check("post_reset_none_free", 32'(none_free), 32'd0);
    check("post_reset_err", 32'(err_double_free), 32'd0);
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    check("post_reset_gnt", 32'(alloc_gnt), 32'h3);
    check("post_reset_idx", 32'(alloc_idx), 32'({3'd1, 3'd0}));

    // flush frees of free slots raise no error
    apply(2'b00, 2'b01, 3'd4, 3'd0, 1'b1);
    tick();
    check("flush_free_no_err", 32'(err_double_free), 32'd0);
    check("flush_free_count", 32'(free_count), 32'd8);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
